// File: rtl/lsu_mem_initiator_if.sv
// Memory data-port bundle between the load/store unit (master) and the memory (slave).
// The request is a one-cycle pulse on mem_req_valid; the response is a one-cycle pulse on mem_resp_valid.
interface lsu_mem_initiator_if #(
    parameter int XLEN   = 64,
    parameter int AWIDTH = 32
);
    logic              mem_req_valid;
    logic [AWIDTH-1:0] mem_req_addr;
    logic [7:0]        mem_req_mask;
    logic [2:0]        mem_req_op;
    logic [XLEN-1:0]   mem_req_wdata;
    logic              mem_req_memen;
    logic              mem_req_wen;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_mask, mem_req_op,
               mem_req_wdata, mem_req_memen, mem_req_wen,
        input  mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_mask, mem_req_op,
               mem_req_wdata, mem_req_memen, mem_req_wen,
        output mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store unit: builds lane mask and shifted store data, waits for the
// memory response (bounded by TIMEOUT), then aligns and extends load data for writeback.
module lsu_mem_initiator #(
    parameter int XLEN    = 64,
    parameter int AWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    // Both core-side ports use valid/ready: a transfer happens on a rising clock edge where
    // valid and ready are both high; valid and its payload stay stable until that edge.
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AWIDTH-1:0]   in_addr,
    input  logic [2:0]          in_op,
    input  logic                in_wen,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_rdata,
    output logic [1:0]          out_exc,
    lsu_mem_initiator_if.master mem,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_TIMEOUT  = 2'd2;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd3;
    localparam logic [7:0] CNT_LAST     = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_rdata_q, out_rdata_d;
    logic [1:0]        out_exc_q, out_exc_d;
    logic              req_valid_q, req_valid_d;
    logic [AWIDTH-1:0] req_addr_q, req_addr_d;
    logic [7:0]        req_mask_q, req_mask_d;
    logic [2:0]        req_op_q, req_op_d;
    logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
    logic              req_wen_q, req_wen_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        off_q, off_d;
    logic [2:0]        op_q, op_d;
    logic              wen_q, wen_d;

    logic [7:0]        cnt_inc;
    logic              cnt_expired;
    logic [XLEN-1:0]   resp_data;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [2:0] off);
        case (op)
            3'd1, 3'd5: is_misaligned = off[0];
            3'd2, 3'd6: is_misaligned = (off[1:0] != 2'b00);
            3'd3:       is_misaligned = (off != 3'b000);
            default:    is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [2:0] op, input logic [2:0] off);
        logic [7:0] base;
        case (op)
            3'd0, 3'd4: base = 8'h01;
            3'd1, 3'd5: base = 8'h03;
            3'd2, 3'd6: base = 8'h0F;
            default:    base = 8'hFF;
        endcase
        lane_mask = base << off;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] op, input logic [2:0] off,
                                                    input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] sh;
        sh = raw >> {off, 3'b000};
        case (op)
            3'd0:    load_extend = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'd1:    load_extend = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'd2:    load_extend = {{(XLEN-32){sh[31]}}, sh[31:0]};
            3'd4:    load_extend = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'd5:    load_extend = {{(XLEN-16){1'b0}}, sh[15:0]};
            3'd6:    load_extend = {{(XLEN-32){1'b0}}, sh[31:0]};
            default: load_extend = sh;
        endcase
    endfunction

    assign cnt_inc     = cnt_q + 8'd1;
    assign cnt_expired = (cnt_q >= CNT_LAST);
    // Stores report zero data; loads are aligned from the lane they were requested in.
    assign resp_data   = wen_q ? '0 : load_extend(op_q, off_q, mem.mem_resp_rdata);

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_rdata_d = out_rdata_q;
        out_exc_d   = out_exc_q;
        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;
        req_mask_d  = req_mask_q;
        req_op_d    = req_op_q;
        req_wdata_d = req_wdata_q;
        req_wen_d   = req_wen_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        op_d        = op_q;
        wen_d       = wen_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    off_d      = in_addr[2:0];
                    op_d       = in_op;
                    wen_d      = in_wen;
                    cnt_d      = 8'd0;
                    in_ready_d = 1'b0;
                    if (in_op == 3'd7) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_exc_d   = EXC_ILLEGAL;
                        out_rdata_d = '0;
                    end else if (is_misaligned(in_op, in_addr[2:0])) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_exc_d   = EXC_MISALIGN;
                        out_rdata_d = '0;
                    end else begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = {in_addr[AWIDTH-1:3], 3'b000};
                        req_mask_d  = lane_mask(in_op, in_addr[2:0]);
                        req_op_d    = in_op;
                        req_wdata_d = in_wdata << {in_addr[2:0], 3'b000};
                        req_wen_d   = in_wen;
                    end
                end
            end

            S_REQ: begin
                req_addr_d  = '0;
                req_mask_d  = '0;
                req_op_d    = '0;
                req_wdata_d = '0;
                req_wen_d   = 1'b0;
                cnt_d       = 8'd0;
                // A flushed request whose response is already here has nothing left to drain.
                if (flush) begin
                    state_d    = mem.mem_resp_valid ? S_IDLE : S_DRAIN;
                    in_ready_d = mem.mem_resp_valid;
                end else if (mem.mem_resp_valid) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_exc_d   = EXC_NONE;
                    out_rdata_d = resp_data;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (flush) begin
                    state_d    = mem.mem_resp_valid ? S_IDLE : S_DRAIN;
                    in_ready_d = mem.mem_resp_valid;
                    cnt_d      = cnt_inc;
                end else if (mem.mem_resp_valid) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_exc_d   = EXC_NONE;
                    out_rdata_d = resp_data;
                end else if (cnt_expired) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_exc_d   = EXC_TIMEOUT;
                    out_rdata_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DRAIN: begin
                if (mem.mem_resp_valid || cnt_expired) begin
                    state_d    = S_IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DONE: begin
                if (flush || out_ready) begin
                    state_d     = S_IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    out_rdata_d = '0;
                    out_exc_d   = EXC_NONE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
            out_exc_q   <= EXC_NONE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_mask_q  <= '0;
            req_op_q    <= '0;
            req_wdata_q <= '0;
            req_wen_q   <= 1'b0;
            cnt_q       <= '0;
            off_q       <= '0;
            op_q        <= '0;
            wen_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_rdata_q <= out_rdata_d;
            out_exc_q   <= out_exc_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_mask_q  <= req_mask_d;
            req_op_q    <= req_op_d;
            req_wdata_q <= req_wdata_d;
            req_wen_q   <= req_wen_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            op_q        <= op_d;
            wen_q       <= wen_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign out_rdata         = out_rdata_q;
    assign out_exc           = out_exc_q;
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = req_addr_q;
    assign mem.mem_req_mask  = req_mask_q;
    assign mem.mem_req_op    = req_op_q;
    assign mem.mem_req_wdata = req_wdata_q;
    assign mem.mem_req_memen = req_valid_q;
    assign mem.mem_req_wen   = req_wen_q & req_valid_q;
    assign dbg_state         = state_q;

endmodule
